// File: rtl/icache_param_if.sv
// Datapath and memory-controller signals of the instruction cache.
// master = datapath/memory side, slave = the cache itself.
interface icache_param_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_param.sv
// Direct-mapped instruction cache with zero-cycle hits and word-by-word block fill.
// Define ICACHE_STATS_EN to add the hit_count/miss_count performance counters.
module icache_param #(
    parameter int unsigned SETS        = 16,
    parameter int unsigned BLOCK_WORDS = 2
) (
    input  logic          CLK,
    input  logic          RST,
    icache_param_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
`endif
);
    localparam int unsigned WO    = $clog2(BLOCK_WORDS);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - WO - IDX_W;
    localparam int unsigned CNT_W = (WO == 0) ? 1 : WO;
    localparam int unsigned AW    = $clog2(SETS * BLOCK_WORDS);

    typedef enum logic {IDLE, FILL} state_e;

    state_e             state_q;
    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tags_q [SETS];
    logic [31:0]        data_q [SETS*BLOCK_WORDS];
    logic [TAG_W-1:0]   fill_tag_q;
    logic [IDX_W-1:0]   fill_idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               iren_q;
    logic [31:0]        iaddr_q;

    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   req_idx;
    logic [CNT_W-1:0]   req_off;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_ptr;
    logic [31:0]        blk_base;
    logic               lookup;
    logic               hit;
    logic               miss;
    logic               last_word;
    logic               fill_we;

    always_comb begin
        req_tag   = TAG_W'(bus.imemaddr >> (2 + WO + IDX_W));
        req_idx   = IDX_W'(bus.imemaddr >> (2 + WO));
        req_off   = CNT_W'(bus.imemaddr[31:2] & 30'(BLOCK_WORDS - 1));
        blk_base  = (bus.imemaddr >> (2 + WO)) << (2 + WO);
        rd_ptr    = AW'(32'(req_idx) * BLOCK_WORDS + 32'(req_off));
        wr_ptr    = AW'(32'(fill_idx_q) * BLOCK_WORDS + 32'(cnt_q));
        lookup    = (state_q == IDLE) && bus.imemREN && !bus.flush && !RST;
        hit       = lookup && valid_q[req_idx] && (tags_q[req_idx] == req_tag);
        miss      = lookup && !hit;
        last_word = (cnt_q == CNT_W'(BLOCK_WORDS - 1));
        fill_we   = (state_q == FILL) && !bus.iwait && !bus.flush && !RST;
    end

    assign bus.ihit     = hit;
    assign bus.imemload = hit ? data_q[rd_ptr] : '0;
    // Memory request is held low while reset is asserted, not just after the edge.
    assign bus.iREN     = iren_q & ~RST;
    assign bus.iaddr    = RST ? '0 : iaddr_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            cnt_q      <= '0;
            iren_q     <= 1'b0;
            iaddr_q    <= '0;
            fill_tag_q <= '0;
            fill_idx_q <= '0;
        end else if (bus.flush) begin
            state_q <= IDLE;
            valid_q <= '0;
            cnt_q   <= '0;
            iren_q  <= 1'b0;
            iaddr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        // The victim set stays invalid until its last word lands.
                        state_q          <= FILL;
                        fill_tag_q       <= req_tag;
                        fill_idx_q       <= req_idx;
                        cnt_q            <= '0;
                        iren_q           <= 1'b1;
                        iaddr_q          <= blk_base;
                        valid_q[req_idx] <= 1'b0;
                    end
                end
                FILL: begin
                    if (!bus.iwait) begin
                        if (last_word) begin
                            state_q             <= IDLE;
                            valid_q[fill_idx_q] <= 1'b1;
                            cnt_q               <= '0;
                            iren_q              <= 1'b0;
                            iaddr_q             <= '0;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                            iaddr_q <= iaddr_q + 32'd4;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_we) begin
            data_q[wr_ptr]     <= bus.iload;
            tags_q[fill_idx_q] <= fill_tag_q;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_param.sv
// Bench for icache_param: directed literal sequences plus randomized traffic
// checked every cycle against a block-level model of cache contents.
module tb_icache_param;
    localparam int unsigned SETS = 16;
    localparam int unsigned BW   = 2;
    localparam int unsigned WO   = $clog2(BW);
    localparam int unsigned IW   = $clog2(SETS);

    logic CLK = 1'b0;
    logic RST;
    int unsigned checks = 0;
    int unsigned errors = 0;

    icache_param_if bus();
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_param #(.SETS(SETS), .BLOCK_WORDS(BW)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    // Backing memory: every address holds a fixed, address-derived word.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    always_comb bus.iload = memfn(bus.iaddr);

    function automatic int unsigned set_of(input logic [31:0] a);
        return (a / (4 * BW)) % SETS;
    endfunction

    function automatic logic [31:0] base_of(input logic [31:0] a);
        return a - (a % (4 * BW));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: which block (by base address) each set holds, and the fill in flight.
    bit          m_valid [SETS];
    logic [31:0] m_base  [SETS];
    bit          m_fill;
    logic [31:0] m_fbase;
    int unsigned m_k;
    int unsigned m_set;
    logic [31:0] m_hits;
    logic [31:0] m_misses;
    bit          armed = 1'b0;

    bit          e_hit;
    bit          e_ren;
    logic [31:0] e_load;
    logic [31:0] e_addr;
    int unsigned s;

    always @(negedge CLK) begin
        s      = set_of(bus.imemaddr);
        e_hit  = !RST && !m_fill && bus.imemREN && !bus.flush
                 && m_valid[s] && (m_base[s] == base_of(bus.imemaddr));
        e_load = e_hit ? memfn(bus.imemaddr) : 32'd0;
        e_ren  = !RST && m_fill;
        e_addr = e_ren ? m_fbase + 32'(4 * m_k) : 32'd0;
        if (armed) begin
            chk("ihit", 32'(bus.ihit), 32'(e_hit));
            chk("imemload", bus.imemload, e_load);
            chk("iREN", 32'(bus.iREN), 32'(e_ren));
            chk("iaddr", bus.iaddr, e_addr);
`ifdef ICACHE_STATS_EN
            chk("hit_count", hit_count, m_hits);
            chk("miss_count", miss_count, m_misses);
`endif
        end
        if (RST) begin
            for (int unsigned i = 0; i < SETS; i++) m_valid[i] = 1'b0;
            m_fill   = 1'b0;
            m_hits   = '0;
            m_misses = '0;
            armed    = 1'b1;
        end else begin
            if (e_hit) m_hits = m_hits + 32'd1;
            if (bus.flush) begin
                for (int unsigned i = 0; i < SETS; i++) m_valid[i] = 1'b0;
                m_fill = 1'b0;
            end else if (m_fill) begin
                if (!bus.iwait) begin
                    m_k++;
                    if (m_k == BW) begin
                        m_valid[m_set] = 1'b1;
                        m_base[m_set]  = m_fbase;
                        m_fill         = 1'b0;
                    end
                end
            end else if (bus.imemREN && !e_hit) begin
                m_fill     = 1'b1;
                m_fbase    = base_of(bus.imemaddr);
                m_set      = s;
                m_k        = 0;
                m_valid[s] = 1'b0;
                m_misses   = m_misses + 32'd1;
            end
        end
    end

    task automatic drive(input bit rst, input bit ren, input logic [31:0] a,
                         input bit fl, input bit w);
        @(posedge CLK);
        #1;
        RST          = rst;
        bus.imemREN  = ren;
        bus.imemaddr = a;
        bus.flush    = fl;
        bus.iwait    = w;
        @(negedge CLK);
    endtask

    initial begin
        logic [31:0] a;
        RST          = 1'b1;
        bus.imemREN  = 1'b0;
        bus.imemaddr = '0;
        bus.flush    = 1'b0;
        bus.iwait    = 1'b0;

        drive(1, 0, 32'h0, 0, 0);
        drive(1, 0, 32'h0, 0, 0);
        chk("rst_ihit", 32'(bus.ihit), 32'd0);
        chk("rst_iren", 32'(bus.iREN), 32'd0);
        chk("rst_iaddr", bus.iaddr, 32'd0);
        chk("rst_load", bus.imemload, 32'd0);

        // Cold miss on 0x40, two-word fill, hit three cycles later.
        drive(0, 1, 32'h40, 0, 0);
        chk("c0_miss", 32'(bus.ihit), 32'd0);
        drive(0, 1, 32'h40, 0, 0);
        chk("c1_iren", 32'(bus.iREN), 32'd1);
        chk("c1_iaddr", bus.iaddr, 32'h40);
        drive(0, 1, 32'h40, 0, 0);
        chk("c2_iaddr", bus.iaddr, 32'h44);
        drive(0, 1, 32'h40, 0, 0);
        chk("c3_hit", 32'(bus.ihit), 32'd1);
        chk("c3_load", bus.imemload, 32'hC09E_0000);
        chk("c3_iren", 32'(bus.iREN), 32'd0);
        drive(0, 1, 32'h44, 0, 0);
        chk("w1_hit", 32'(bus.ihit), 32'd1);
        chk("w1_load", bus.imemload, 32'hC09A_0000);
        chk("w1_iren", 32'(bus.iREN), 32'd0);

        // Conflicting tag evicts the 0x40 block.
        drive(0, 1, 32'h440, 0, 0);
        chk("ev_miss", 32'(bus.ihit), 32'd0);
        drive(0, 1, 32'h440, 0, 0);
        chk("ev_iaddr0", bus.iaddr, 32'h440);
        drive(0, 1, 32'h440, 0, 0);
        chk("ev_iaddr1", bus.iaddr, 32'h444);
        drive(0, 1, 32'h440, 0, 0);
        chk("ev_load", bus.imemload, 32'hC49E_0000);
        drive(0, 1, 32'h40, 0, 0);
        chk("ev_old_miss", 32'(bus.ihit), 32'd0);
        // Fill completes for 0x40 even though the request goes away.
        drive(0, 0, 32'h1000, 0, 0);
        chk("drop_iaddr0", bus.iaddr, 32'h40);
        drive(0, 0, 32'h1000, 0, 0);
        chk("drop_iaddr1", bus.iaddr, 32'h44);
        drive(0, 1, 32'h40, 0, 0);
        chk("drop_hit", bus.imemload, 32'hC09E_0000);

        // Wait states on the first fill word.
        drive(0, 0, 32'h0, 1, 0);
        drive(0, 1, 32'h40, 0, 1);
        chk("ws_miss", 32'(bus.ihit), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'h40, 0, 1);
            chk("ws_hold_iaddr", bus.iaddr, 32'h40);
        end
        drive(0, 1, 32'h40, 0, 0);
        chk("ws_w0_iaddr", bus.iaddr, 32'h40);
        drive(0, 1, 32'h40, 0, 0);
        chk("ws_w1_iaddr", bus.iaddr, 32'h44);
        drive(0, 1, 32'h40, 0, 0);
        chk("ws_hit", 32'(bus.ihit), 32'd1);

        // Flush during word 0 aborts the fill.
        drive(0, 1, 32'h80, 0, 0);
        drive(0, 1, 32'h80, 1, 1);
        chk("fl_iren", 32'(bus.iREN), 32'd1);
        chk("fl_ihit", 32'(bus.ihit), 32'd0);
        drive(0, 1, 32'h80, 0, 0);
        chk("fl_after_iren", 32'(bus.iREN), 32'd0);
        chk("fl_after_miss", 32'(bus.ihit), 32'd0);
        drive(0, 1, 32'h80, 0, 0);
        drive(0, 1, 32'h80, 0, 0);
        drive(0, 1, 32'h80, 0, 0);
        chk("fl_refill_hit", 32'(bus.ihit), 32'd1);

`ifdef ICACHE_STATS_EN
        drive(1, 0, 32'h0, 0, 0);
        drive(0, 1, 32'h40, 0, 0);
        drive(0, 1, 32'h40, 0, 0);
        drive(0, 1, 32'h40, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, (i % 2 == 0) ? 32'h40 : 32'h44, 0, 0);
        drive(0, 1, 32'h100, 0, 0);
        drive(0, 0, 32'h0, 0, 0);
        chk("st_hits", hit_count, 32'd5);
        chk("st_misses", miss_count, 32'd2);
        drive(1, 0, 32'h0, 0, 0);
        chk("st_rst_hits", hit_count, 32'd0);
        chk("st_rst_misses", miss_count, 32'd0);
`endif

        // Randomized traffic over a small tag pool so hits and conflicts are frequent.
        for (int n = 0; n < 3000; n++) begin
            a = (32'($urandom_range(0, 3)) << (2 + WO + IW))
              | (32'($urandom_range(0, SETS - 1)) << (2 + WO))
              | (32'($urandom_range(0, BW - 1)) << 2);
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, a,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
